// File: rtl/verbus_arbiter_pkg.sv
// verbus_arbiter_pkg: shared state encoding and constants for multi-master Verbus blocks
package verbus_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  localparam logic [3:0] WSTROBE_READ = '0;
endpackage

// File: rtl/verbus_arbiter_rr_picker.sv
// rr_picker: first set request scanning circularly from rr_ptr
module rr_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] index
);
  localparam int IW = $clog2(N_REQ);
  always_comb begin
    any = |req;
    index = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % N_REQ]) index = IW'((int'(rr_ptr) + k) % N_REQ);
  end
endmodule

// File: rtl/verbus_arbiter.sv
// verbus_arbiter: round-robin sharing of one Verbus memory port with a per-transaction watchdog
module verbus_arbiter
  import verbus_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*32-1:0]      req_address,
  input  logic [N_REQ*4-1:0]       req_wstrobe,
  input  logic [N_REQ*32-1:0]      req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [31:0]              req_rdata,
  output logic                     mem_valid,
  output logic [31:0]              mem_address,
  output logic [3:0]               mem_wstrobe,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic                     timeout_flag,
  output logic [$clog2(N_REQ)-1:0] timeout_id,
  input  logic                     timeout_clear
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  arb_state_t state, state_n;
  logic [IW-1:0] grant_id, grant_n, rr_ptr, rr_n, pick, tid_n;
  logic [WW-1:0] wd_count, wd_n;
  logic any, busy, wd_hit, done, flag_n;
  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .any(any),
    .index(pick)
  );
  always_comb begin
    busy = state == BUSY;
    wd_hit = TIMEOUT > 0 && busy && !mem_ready && wd_count == WW'(TIMEOUT - 1);
    done = busy && (mem_ready || wd_hit);
    state_n = busy ? (done ? IDLE : BUSY) : (any ? BUSY : IDLE);
    grant_n = !busy && any ? pick : grant_id;
    rr_n = done ? (grant_id == IW'(N_REQ - 1) ? '0 : grant_id + 1'b1) : rr_ptr;
    wd_n = !busy ? '0 : (!mem_ready && wd_count != '1) ? wd_count + 1'b1 : wd_count;
    flag_n = wd_hit || (timeout_flag && !timeout_clear);
    tid_n = wd_hit ? grant_id : timeout_id;
    mem_valid = busy && req_valid[grant_id] && !wd_hit;
    mem_address = busy ? req_address[grant_id*32 +: 32] : '0;
    mem_wstrobe = busy ? req_wstrobe[grant_id*4 +: 4] : WSTROBE_READ;
    mem_wdata = busy ? req_wdata[grant_id*32 +: 32] : '0;
    req_ready = done ? N_REQ'(1) << grant_id : '0;
    req_rdata = busy && !wd_hit ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      wd_count <= '0;
      timeout_flag <= 1'b0;
      timeout_id <= '0;
    end else begin
      state <= state_n;
      grant_id <= grant_n;
      rr_ptr <= rr_n;
      wd_count <= wd_n;
      timeout_flag <= flag_n;
      timeout_id <= tid_n;
    end
  end
endmodule
